// File: rtl/change_dispenser.sv
// change_dispenser: executes one vend/change transaction handed over by the
// vending FSM. It releases the product, then pays out up to three 5-unit
// coins, one per hopper sense pulse, and reports done or a sticky jam fault.
//
// Handshake: a transaction is accepted on any rising clk edge where
// valid && ready. ready is high only while the block sits in IDLE; valid
// seen while ready is low is dropped, never queued.
//
// Every output is a flop. Outputs are loaded from the next-state value, so
// they line up with the state they describe.
// TIMEOUT must be below 2**TMR_W.
module change_dispenser #(
  parameter int TMR_W   = 8,
  parameter int TIMEOUT = 200,
  parameter int TOT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             vend,
  input  logic [1:0]       change,
  output logic             ready,
  input  logic             prod_sense,
  input  logic             coin_sense,
  output logic             prod_motor,
  output logic             coin_motor,
  output logic             done,
  output logic             fault,
  input  logic             clr_fault,
  output logic [1:0]       coins_left,
  output logic [TOT_W-1:0] total_coins,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRODUCT = 3'd1,
    S_COIN    = 3'd2,
    S_DONE    = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [TMR_W-1:0]   timer, timer_n, timer_inc;
  logic [1:0]         coins_n;
  logic [TOT_W-1:0]   total_n;
  logic               timeout_hit;

  // Bit 0 and 1 are the two synchronizer stages; bit 2 is the previous
  // synchronized value used for rising-edge detection.
  logic [2:0]         prod_sync;
  logic [2:0]         coin_sync;
  logic               prod_edge;
  logic               coin_edge;

  // Synchronize both sensors and keep one history bit for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_sync <= 3'b000;
      coin_sync <= 3'b000;
    end else begin
      prod_sync <= {prod_sync[1:0], prod_sense};
      coin_sync <= {coin_sync[1:0], coin_sense};
    end
  end

  // A sensor rising edge becomes visible here after two edges and is acted
  // on at the third.
  assign prod_edge = prod_sync[1] & ~prod_sync[2];
  assign coin_edge = coin_sync[1] & ~coin_sync[2];

  // The step times out on the edge where the timer would reach TIMEOUT,
  // i.e. exactly TIMEOUT edges after it was last cleared.
  assign timer_inc   = timer + {{(TMR_W-1){1'b0}}, 1'b1};
  assign timeout_hit = (timer_inc == TMR_W'(TIMEOUT));

  // Next-state, timer, coin and total computation; sense edges take
  // priority over a timeout on the same cycle.
  always_comb begin
    state_n = state;
    timer_n = timer;
    coins_n = coins_left;
    total_n = total_coins;
    case (state)
      S_IDLE: begin
        if (valid) begin
          coins_n = change;
          timer_n = '0;
          if (vend)               state_n = S_PRODUCT;
          else if (change != 2'd0) state_n = S_COIN;
          else                     state_n = S_DONE;
        end
      end
      S_PRODUCT: begin
        if (prod_edge) begin
          timer_n = '0;
          state_n = (coins_left != 2'd0) ? S_COIN : S_DONE;
        end else if (timeout_hit) begin
          state_n = S_FAULT;
        end else begin
          timer_n = timer_inc;
        end
      end
      S_COIN: begin
        if (coin_edge) begin
          timer_n = '0;
          coins_n = coins_left - 2'd1;
          if (!(&total_coins)) total_n = total_coins + TOT_W'(1);
          if (coins_left == 2'd1) state_n = S_DONE;
        end else if (timeout_hit) begin
          state_n = S_FAULT;
        end else begin
          timer_n = timer_inc;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      S_FAULT: begin
        if (clr_fault) begin
          state_n = S_IDLE;
          coins_n = 2'd0;
          timer_n = '0;
        end
      end
      default: begin
        state_n = S_IDLE;
        coins_n = 2'd0;
        timer_n = '0;
      end
    endcase
  end

  // State, counters and registered outputs; reset drops the motors at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      timer       <= '0;
      coins_left  <= 2'd0;
      total_coins <= '0;
      ready       <= 1'b1;
      prod_motor  <= 1'b0;
      coin_motor  <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      coins_left  <= coins_n;
      total_coins <= total_n;
      ready       <= (state_n == S_IDLE);
      prod_motor  <= (state_n == S_PRODUCT);
      coin_motor  <= (state_n == S_COIN);
      done        <= (state_n == S_DONE);
      fault       <= (state_n == S_FAULT);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed and randomized transactions against a
// transaction-level model (coins paid, saturating total, fixed sensor
// latency of three clock edges, timeout after TIMEOUT idle edges).
module tb_change_dispenser;

  localparam int TMR_W   = 8;
  localparam int TIMEOUT = 30;
  localparam int TOT_W   = 3;
  localparam int TOT_MAX = (1 << TOT_W) - 1;

  logic             clk;
  logic             rst;
  logic             valid;
  logic             vend;
  logic [1:0]       change;
  logic             ready;
  logic             prod_sense;
  logic             coin_sense;
  logic             prod_motor;
  logic             coin_motor;
  logic             done;
  logic             fault;
  logic             clr_fault;
  logic [1:0]       coins_left;
  logic [TOT_W-1:0] total_coins;
  logic [2:0]       state_dbg;

  int total;
  int bad;
  int exp_total;
  logic [1:0] exp_q[$];

  change_dispenser #(.TMR_W(TMR_W), .TIMEOUT(TIMEOUT), .TOT_W(TOT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .vend       (vend),
    .change     (change),
    .ready      (ready),
    .prod_sense (prod_sense),
    .coin_sense (coin_sense),
    .prod_motor (prod_motor),
    .coin_motor (coin_motor),
    .done       (done),
    .fault      (fault),
    .clr_fault  (clr_fault),
    .coins_left (coins_left),
    .total_coins(total_coins),
    .state_dbg  (state_dbg)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present a transaction for one edge; the model queues the coins_left
  // value expected after each paid coin.
  task automatic accept(input logic v, input logic [1:0] c);
    valid  = 1'b1;
    vend   = v;
    change = c;
    tick();
    valid  = 1'b0;
    vend   = 1'b0;
    change = 2'd0;
    check("ready_low_after_accept", ready, 0);
    exp_q.delete();
    for (int k = int'(c) - 1; k >= 0; k--) exp_q.push_back(2'(k));
  endtask

  // Wait d edges, pulse the product sensor, check the 3-edge latency.
  task automatic prod_step(input int d, input logic noise, input logic [1:0] c);
    repeat (d) begin
      if (noise) begin
        valid  = 1'b1;
        change = ~c;
      end
      tick();
    end
    valid  = 1'b0;
    change = 2'd0;
    prod_sense = 1'b1;
    tick();
    tick();
    check("prod_motor_hold", prod_motor, 1);
    prod_sense = 1'b0;
    tick();
    check("prod_motor_drop", prod_motor, 0);
    check("coins_after_prod", coins_left, c);
  endtask

  // Wait d edges, pulse the hopper sensor, check decrement and total.
  task automatic coin_step(input int d);
    logic [1:0] exp;
    exp = exp_q.pop_front();
    repeat (d) tick();
    check("coin_motor_on", coin_motor, 1);
    coin_sense = 1'b1;
    tick();
    tick();
    check("coins_hold", coins_left, exp + 2'd1);
    coin_sense = 1'b0;
    tick();
    if (exp_total < TOT_MAX) exp_total++;
    check("coins_dec", coins_left, exp);
    check("total_coins", total_coins, exp_total);
    if (exp == 2'd0) begin
      check("done_after_last_coin", done, 1);
      check("coin_motor_off", coin_motor, 0);
    end else begin
      check("coin_motor_still_on", coin_motor, 1);
    end
  endtask

  // Full transaction; pd / cd < 0 select random sensor delays.
  task automatic run_txn(input logic v, input logic [1:0] c, input logic noise,
                         input int pd, input int cd);
    int n;
    accept(v, c);
    if (v) begin
      check("prod_motor_on", prod_motor, 1);
      prod_step((pd < 0) ? $urandom_range(1, 8) : pd, noise, c);
    end
    if (c == 2'd0) begin
      check("done_pulse", done, 1);
      check("no_coin_motor", coin_motor, 0);
    end else begin
      check("coins_loaded", coins_left, c);
      n = int'(c);
      for (int k = 0; k < n; k++) coin_step((cd < 0) ? $urandom_range(0, 8) : cd);
    end
    tick();
    check("done_one_cycle", done, 0);
    check("ready_back", ready, 1);
    check("total_end", total_coins, exp_total);
  endtask

  // directed + random sequence
  initial begin
    total = 0; bad = 0; exp_total = 0;
    rst = 1'b0; valid = 1'b0; vend = 1'b0; change = 2'd0;
    prod_sense = 1'b0; coin_sense = 1'b0; clr_fault = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_motors", {prod_motor, coin_motor}, 0);
    check("rst_coins", coins_left, 0);
    check("rst_total", total_coins, 0);
    rst = 1'b1;
    tick();

    // Reset in the middle of a coin payout.
    accept(1'b0, 2'd2);
    tick();
    check("coin_motor_before_rst", coin_motor, 1);
    #2 rst = 1'b0;
    #1;
    check("async_motor_drop", coin_motor, 0);
    check("async_ready", ready, 1);
    tick();
    rst = 1'b1;
    tick();
    exp_total = 0;
    check("ready_after_rst", ready, 1);
    check("total_after_rst", total_coins, 0);

    // vend with two coins
    run_txn(1'b1, 2'd2, 1'b0, 5, 3);
    // nothing to do: done the cycle after acceptance
    run_txn(1'b0, 2'd0, 1'b0, -1, -1);
    // re-asserted valid during PRODUCT is ignored
    run_txn(1'b1, 2'd1, 1'b1, 6, 2);
    // sense edges landing exactly on the timeout cycle still count
    run_txn(1'b1, 2'd1, 1'b0, TIMEOUT - 3, TIMEOUT - 3);

    // Stray coin edge while idle changes nothing.
    coin_sense = 1'b1;
    tick(); tick();
    coin_sense = 1'b0;
    tick(); tick();
    check("stray_coin_total", total_coins, exp_total);
    check("stray_coin_left", coins_left, 0);
    check("stray_coin_motor", coin_motor, 0);

    // Coin jam after one coin; clr_fault ignored while in COIN.
    accept(1'b0, 2'd3);
    coin_step(2);
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    check("clr_ignored_in_coin", coin_motor, 1);
    repeat (TIMEOUT - 3) tick();
    check("no_fault_yet_a", fault, 0);
    tick();
    check("no_fault_yet_b", fault, 0);
    tick();
    check("jam_fault", fault, 1);
    check("jam_motor_off", coin_motor, 0);
    check("jam_coins_frozen", coins_left, 2);
    check("jam_not_ready", ready, 0);
    tick();
    check("fault_sticky", fault, 1);
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    check("clr_fault", fault, 0);
    check("clr_ready", ready, 1);
    check("clr_coins", coins_left, 0);
    check("clr_total", total_coins, exp_total);

    // Product jam: no prod_sense at all.
    accept(1'b1, 2'd1);
    repeat (TIMEOUT - 1) tick();
    check("prod_no_fault_yet", fault, 0);
    tick();
    check("prod_jam_fault", fault, 1);
    check("prod_jam_motor", prod_motor, 0);
    check("prod_jam_coins", coins_left, 1);
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    check("prod_clr_ready", ready, 1);

    // Random transactions; total saturates at TOT_MAX along the way.
    for (int i = 0; i < 10; i++) begin
      run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), -1, -1);
      repeat ($urandom_range(0, 3)) tick();
    end
    run_txn(1'b0, 2'd3, 1'b0, -1, -1);
    run_txn(1'b0, 2'd3, 1'b0, -1, -1);
    check("total_saturated", total_coins, TOT_MAX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream executor for the vending controller's product/change outputs.
- Accepts one transaction per request: a vend flag plus a 2-bit change code. Drives the product-release motor, then the coin-hopper motor, one 5-unit coin per hopper sense pulse.
- Reports completion or a jam fault back to the controller.
- Sits between the vending FSM and the electromechanical actuators/sensors.

Parameters:
- TMR_W, 8, width of the jam-timeout counter.
- TIMEOUT, 200, cycles allowed per actuator step (product release or next coin) before fault; must be < 2^TMR_W.
- TOT_W, 8, width of the saturating total-coins-dispensed counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- valid  in  1  transaction strobe from vending FSM
- vend  in  1  release one product
- change  in  2  coins of 5 units to return: 00=0, 01=1, 10=2, 11=3
- ready  out  1  high only in IDLE; transaction accepted when valid&ready
- prod_sense  in  1  product-drop sensor, asynchronous, active-high pulse
- coin_sense  in  1  hopper coin-exit sensor, asynchronous, active-high pulse (≥2 clk wide)
- prod_motor  out  1  product-release actuator enable
- coin_motor  out  1  hopper motor enable
- done  out  1  one-cycle pulse: transaction finished
- fault  out  1  jam detected; sticky
- clr_fault  in  1  clears fault, returns to IDLE
- coins_left  out  2  remaining coins in current transaction
- total_coins  out  TOT_W  saturating count of coins dispensed since reset

Behaviour:
- Reset (rst=0, async):
  - All outputs 0 except ready=1.
  - State IDLE, timer 0, coins_left 0, total_coins 0.
  - Motors drop immediately, mid-operation included.
- Sense inputs:
  - Each passes a 2-flop synchronizer plus a rising-edge detector.
  - A sensor rising edge is acted on at the 3rd clk edge after it.
  - Edges outside the state that uses them are ignored.
- States: IDLE, PRODUCT, COIN, DONE, FAULT. All outputs are registered.
- IDLE: ready=1.
  - On valid at edge N: latch coins_left=change and the vend flag.
  - Next state is PRODUCT if vend, else COIN if change≠0, else DONE. ready=0 from cycle N+1.
- PRODUCT: prod_motor=1, timer counts each cycle.
  - On prod_sense edge: prod_motor=0, timer cleared; go to COIN if coins_left≠0, else DONE.
  - If timer reaches TIMEOUT: go to FAULT.
- COIN: coin_motor=1.
  - Each coin_sense edge: coins_left−1, total_coins+1 (saturating at all-ones), timer cleared.
  - When coins_left reaches 0: coin_motor=0, go to DONE.
  - If timer reaches TIMEOUT before the next edge: go to FAULT; coins_left holds the undispensed count.
- DONE: done=1 for exactly one cycle, then IDLE (ready=1 the next cycle).
- FAULT: both motors 0, fault=1, ready=0, coins_left frozen.
  - clr_fault=1 at an edge clears fault, coins_left and timer, and returns to IDLE.
  - clr_fault is ignored in every other state.
- Back-to-back transactions: minimum spacing is the DONE cycle plus one IDLE cycle. valid while ready=0 is ignored (not queued).
- Simultaneous events:
  - prod_sense edge and timeout on the same cycle: the sense edge wins.
  - Same rule in COIN: a coin edge on the timeout cycle counts, and the timer clears.
- Extra coin_sense edges after coins_left=0 are ignored; no underflow.

Test Plan:
- Reset mid-COIN: assert rst=0 while coin_motor=1 -> coin_motor=0 asynchronously; after release ready=1, total_coins=0.
- valid, vend=1, change=10; prod_sense pulse after 5 cycles, then two coin_sense pulses -> prod_motor falls 3 clk after the prod pulse; coin_motor then high; coins_left 2→1→0; done pulse; total_coins=2.
- valid, vend=0, change=00 -> DONE the cycle after acceptance; no motor asserted; done pulse; ready=1 two cycles after acceptance.
- valid, vend=0, change=11; one coin_sense pulse, then none -> fault=1 exactly TIMEOUT cycles after the timer cleared; coin_motor=0; coins_left=2. clr_fault -> IDLE, coins_left=0.
- valid re-asserted during PRODUCT with a different change code -> ignored; the original transaction completes unchanged.
- With TOT_W=2, run 2 transactions of change=11 -> total_coins saturates at 3; no wrap.
